// File: rtl/mem_access_unit.sv
// Purpose: RV32I load/store sequencer between the control FSM and a req/ack memory bus.
// Latency: start-to-done is 2 cycles minimum (accept, REQ with ack), plus one cycle per ack wait.
// Backpressure: holds mem_req with stable bus fields until mem_ack; start is ignored while busy.
module mem_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   rdata_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  // Decoded view of the incoming command (only meaningful while IDLE)
  logic              cmd_illegal;
  logic [3:0]        cmd_be;
  logic [XLEN-1:0]   cmd_lanes;

  // Load extraction from the bus word using the latched offset and width
  logic [XLEN-1:0]   rd_shift;
  logic [XLEN-1:0]   ld_ext;

  // Classify the command: byte enables, replicated store lanes, and legality
  always_comb begin
    cmd_illegal = 1'b0;
    cmd_be      = 4'b0000;
    cmd_lanes   = wdata;
    case (funct3[1:0])
      2'b00: begin
        cmd_be    = 4'b0001 << addr[1:0];
        cmd_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        cmd_be      = 4'b0011 << addr[1:0];
        cmd_lanes   = {2{wdata[15:0]}};
        cmd_illegal = addr[0];
      end
      2'b10: begin
        cmd_be      = 4'b1111;
        cmd_lanes   = wdata;
        // 110 has no RV32I meaning; words also need natural alignment
        cmd_illegal = funct3[2] | (addr[1:0] != 2'b00);
      end
      default: begin
        cmd_illegal = 1'b1;
      end
    endcase
  end

  // Select the addressed byte/halfword and extend it per the latched funct3
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state and latch logic for the sequencer
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d     = we;
          funct3_d = funct3;
          off_d    = addr[1:0];
          if (cmd_illegal) begin
            state_d = S_FAULT;
          end else begin
            // Bus fields only change for commands that will actually go out
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = cmd_be;
            wdata_d = cmd_lanes;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = ld_ext;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs come straight from registers or the state decode; nothing from mem_ack
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_FAULT);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q & (state_q == S_REQ);
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;

endmodule
